// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle unsigned restoring divider, one quotient bit per clock
// Optional DZ flag and divide-by-zero fast path under `DIV_ZERO_FLAG_EN.
module seq_divider #(
    parameter int DW = 4,
    parameter int VW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] a,
    input  logic [VW-1:0] b,
    output logic [DW-1:0] q,
    output logic [VW-1:0] r,
    output logic          busy,
`ifdef DIV_ZERO_FLAG_EN
    output logic          dz,
`endif
    output logic          done
);

    localparam int SW = (DW > 1) ? $clog2(DW) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    logic [1:0]    state;
    logic [DW-1:0] dvd;
    logic [VW-1:0] dvs;
    logic [VW-1:0] a_low;
    logic [VW-1:0] part;
    logic [DW-1:0] quo;
    logic [SW-1:0] step;
    logic          zero_div;

    logic [VW:0]   trial;
    logic          fits;
    logic          accept;

    // The partial remainder is always below the divisor, so VW bits suffice
    // between steps; only the shifted trial value needs the extra bit.
    always_comb begin
        trial  = {part, dvd[DW-1]};
        fits   = (trial >= {1'b0, dvs});
        accept = start && ((state == ST_IDLE) || (state == ST_FIN));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            dvd      <= '0;
            dvs      <= '0;
            a_low    <= '0;
            part     <= '0;
            quo      <= '0;
            step     <= '0;
            zero_div <= 1'b0;
            q        <= '0;
            r        <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
            dz       <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
            dz   <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    state <= ST_IDLE;
                end
                ST_RUN: begin
                    dvd  <= {dvd[DW-2:0], 1'b0};
                    part <= fits ? VW'(trial - {1'b0, dvs}) : VW'(trial);
                    quo  <= {quo[DW-2:0], fits};
                    if (step == '0) begin
                        state <= ST_FIN;
                        busy  <= 1'b0;
                    end else begin
                        step <= step - 1'b1;
                    end
                end
                ST_FIN: begin
                    done  <= 1'b1;
                    q     <= zero_div ? '1 : quo;
                    r     <= zero_div ? a_low : part;
`ifdef DIV_ZERO_FLAG_EN
                    dz    <= zero_div;
`endif
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase

            // Acceptance overrides the FIN->IDLE return so back-to-back works.
            if (accept) begin
                dvd      <= a;
                dvs      <= b;
                a_low    <= a[VW-1:0];
                part     <= '0;
                quo      <= '0;
                step     <= SW'(DW - 1);
                zero_div <= (b == '0);
`ifdef DIV_ZERO_FLAG_EN
                if (b == '0) begin
                    state <= ST_FIN;
                    busy  <= 1'b0;
                end else begin
                    state <= ST_RUN;
                    busy  <= 1'b1;
                end
`else
                state    <= ST_RUN;
                busy     <= 1'b1;
`endif
            end
        end
    end

endmodule
